// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT spectrum buffer.
package fft_pkg;
  localparam int FFT_POINT = 256;
  localparam int DATA_W    = 16;
  localparam int MAG_W     = 16;
  localparam int ADDR_W    = 7;
  localparam int BIN_W     = $clog2(FFT_POINT);
  localparam int SQ_W      = 2*DATA_W + 1;
  localparam int HALF_PT   = FFT_POINT / 2;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;
endpackage

// File: rtl/spectrum_dpram.sv
// Simple dual-port RAM holding both spectrum banks, addressed {bank, bin}.
module spectrum_dpram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_spectrum_buf.sv
// Squared-magnitude reduction of the FFT output stream into a ping-pong
// half-spectrum buffer with a stable read bank.
module fft_spectrum_buf
  import fft_pkg::*;
(
  input  logic                     clk_50m,
  input  logic                     rst_n,
  input  logic                     fft_o_valid,
  input  logic                     fft_o_sop,
  input  logic                     fft_o_eop,
  input  logic signed [DATA_W-1:0] fft_o_re,
  input  logic signed [DATA_W-1:0] fft_o_im,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [MAG_W-1:0]         rd_data,
  output logic                     frame_done,
  output logic                     rd_bank,
  output logic                     frame_err
);
  cap_state_t        state, state_nxt;
  logic [BIN_W-1:0]  bin_cnt, bin_cnt_nxt, bin_sel;
  logic              accept, err_nxt, swap_start;
  logic              wr_bank;
  logic [1:0]        swap_pipe;
  logic [2*DATA_W-1:0] re_sq, im_sq;
  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [SQ_W-1:0]   sq_sum;
  logic [MAG_W-1:0]  mag;

  always_comb begin
    state_nxt   = state;
    bin_cnt_nxt = bin_cnt;
    bin_sel     = bin_cnt;
    accept      = 1'b0;
    err_nxt     = 1'b0;
    swap_start  = 1'b0;
    if (fft_o_valid) begin
      case (state)
        IDLE: begin
          if (fft_o_sop) begin
            accept      = 1'b1;
            bin_sel     = '0;
            bin_cnt_nxt = BIN_W'(1);
            state_nxt   = CAPTURE;
          end
        end
        CAPTURE: begin
          accept = 1'b1;
          // A second sop wins over a coincident eop and restarts the frame
          if (fft_o_sop) begin
            err_nxt     = 1'b1;
            bin_sel     = '0;
            bin_cnt_nxt = BIN_W'(1);
          end else if (fft_o_eop) begin
            state_nxt   = IDLE;
            bin_cnt_nxt = '0;
            if (bin_cnt == BIN_W'(FFT_POINT-1)) swap_start = 1'b1;
            else                                err_nxt    = 1'b1;
          end else begin
            bin_cnt_nxt = bin_cnt + BIN_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Multiply stage; the bank is latched with the address so an early
  // wr_bank toggle cannot redirect the tail of the finished frame.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      re_sq   <= '0;
      im_sq   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      re_sq   <= fft_o_re * fft_o_re;
      im_sq   <= fft_o_im * fft_o_im;
      wr_en   <= accept && (bin_sel < BIN_W'(HALF_PT));
      wr_addr <= {wr_bank, bin_sel[ADDR_W-1:0]};
    end
  end

  assign sq_sum = {1'b0, re_sq} + {1'b0, im_sq};
  assign mag    = sq_sum[SQ_W-1 -: MAG_W];

  // wr_bank flips at eop so a back-to-back frame lands in the free bank,
  // while rd_bank waits for the last write to drain.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin_cnt    <= '0;
      frame_err  <= 1'b0;
      wr_bank    <= 1'b1;
      swap_pipe  <= '0;
      rd_bank    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bin_cnt    <= bin_cnt_nxt;
      frame_err  <= err_nxt;
      swap_pipe  <= {swap_pipe[0], swap_start};
      frame_done <= swap_pipe[1];
      if (swap_start)   wr_bank <= ~wr_bank;
      if (swap_pipe[1]) rd_bank <= ~rd_bank;
    end
  end

  spectrum_dpram #(
    .AW(ADDR_W + 1),
    .DW(MAG_W)
  ) u_ram (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (mag),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Scoreboard bench for fft_spectrum_buf: frame events and readout checked
// against a protocol/magnitude model driven alongside the stimulus.
module tb_fft_spectrum_buf;
  localparam int NB = 128;

  logic               clk_50m = 1'b0;
  logic               rst_n = 1'b0;
  logic               fft_o_valid = 1'b0;
  logic               fft_o_sop = 1'b0;
  logic               fft_o_eop = 1'b0;
  logic signed [15:0] fft_o_re = '0;
  logic signed [15:0] fft_o_im = '0;
  logic [6:0]         rd_addr = '0;
  logic [15:0]        rd_data;
  logic               frame_done, rd_bank, frame_err;

  always #10 clk_50m = ~clk_50m;

  fft_spectrum_buf dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .fft_o_valid (fft_o_valid),
    .fft_o_sop   (fft_o_sop),
    .fft_o_eop   (fft_o_eop),
    .fft_o_re    (fft_o_re),
    .fft_o_im    (fft_o_im),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .rd_bank     (rd_bank),
    .frame_err   (frame_err)
  );

  typedef struct {
    bit is_done;
    int edge_no;
  } event_t;

  event_t      ev_q[$];
  int          rd_q[$];
  logic [15:0] cur_frame  [NB];
  logic [15:0] pend_frame [NB];
  logic [15:0] read_model [NB];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  bit          m_capt = 1'b0;
  int          m_cnt = 0;
  logic        exp_bank = 1'b0;
  bit          rd_req = 1'b0;
  event_t      mon_ev;
  int          mon_addr;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mag_of(input int re, input int im);
    longint sq;
    sq = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    return 16'(sq >> 17);
  endfunction

  // Outputs sampled 1 ns after each rising edge; reads compared before a swap is applied
  always @(posedge clk_50m) begin
    #1;
    edge_cnt++;
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        checkOutput("rd_queue_empty", 32'(rd_q.size()), 32'd1);
      end else begin
        mon_addr = rd_q.pop_front();
        checkOutput($sformatf("rd_data[%0d]", mon_addr), 32'(rd_data), 32'(read_model[mon_addr]));
      end
    end
    while (ev_q.size() > 0 && ev_q[0].edge_no < edge_cnt) begin
      mon_ev = ev_q.pop_front();
      checkOutput(mon_ev.is_done ? "missed_done" : "missed_err", 32'd0, 32'd1);
    end
    if (ev_q.size() > 0 && ev_q[0].edge_no == edge_cnt) begin
      mon_ev = ev_q.pop_front();
      if (mon_ev.is_done) begin
        checkOutput("frame_done", 32'(frame_done), 32'd1);
        exp_bank = ~exp_bank;
        checkOutput("rd_bank_swap", 32'(rd_bank), 32'(exp_bank));
        read_model = pend_frame;
      end else begin
        checkOutput("frame_err", 32'(frame_err), 32'd1);
        checkOutput("rd_bank_hold", 32'(rd_bank), 32'(exp_bank));
      end
    end else begin
      if (frame_done) checkOutput("spurious_done", 32'(frame_done), 32'd0);
      if (frame_err)  checkOutput("spurious_err", 32'(frame_err), 32'd0);
    end
  end

  task automatic drive_sample(input logic signed [15:0] re, input logic signed [15:0] im,
                              input bit sop, input bit eop);
    int idx;
    @(negedge clk_50m);
    fft_o_valid = 1'b1;
    fft_o_sop   = sop;
    fft_o_eop   = eop;
    fft_o_re    = re;
    fft_o_im    = im;
    idx = -1;
    if (sop) begin
      if (m_capt) ev_q.push_back('{is_done: 1'b0, edge_no: edge_cnt + 1});
      m_capt = 1'b1;
      idx = 0;
    end else if (m_capt) begin
      idx = m_cnt;
    end
    if (idx >= 0) begin
      if (idx < NB) cur_frame[idx] = mag_of(int'(re), int'(im));
      m_cnt = idx + 1;
      if (eop && !sop) begin
        m_capt = 1'b0;
        if (idx == 255) begin
          pend_frame = cur_frame;
          ev_q.push_back('{is_done: 1'b1, edge_no: edge_cnt + 3});
        end else begin
          ev_q.push_back('{is_done: 1'b0, edge_no: edge_cnt + 1});
        end
      end
    end
  endtask

  // mode 0: re=index, 1: re=0x4000, 2: random, 3: full-scale negative
  task automatic applyStimulus(input int mode, input int n, input int sop2_at,
                               input int eop_at, input int gap_pct);
    logic signed [15:0] re, im;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk_50m);
        fft_o_valid = 1'b0;
        fft_o_sop   = 1'($urandom);
        fft_o_eop   = 1'($urandom);
        fft_o_re    = 16'($urandom);
      end
      case (mode)
        0:       begin re = 16'(i);      im = '0;       end
        1:       begin re = 16'h4000;    im = '0;       end
        3:       begin re = 16'h8000;    im = 16'h8000; end
        default: begin re = 16'($urandom); im = 16'($urandom); end
      endcase
      drive_sample(re, im, (i == 0) || (i == sop2_at), i == eop_at);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50m);
      fft_o_valid = 1'b0;
      fft_o_sop   = 1'b0;
      fft_o_eop   = 1'b0;
    end
  endtask

  task automatic read_bins(input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk_50m);
      rd_addr = 7'(i % NB);
      rd_req  = 1'b1;
      rd_q.push_back(i % NB);
    end
    @(negedge clk_50m);
    rd_req = 1'b0;
  endtask

  task automatic drain_and_read();
    idle_cycles(6);
    checkOutput("events_drained", 32'(ev_q.size()), 32'd0);
    read_bins(NB);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk_50m);
    checkOutput("reset_rd_bank", 32'(rd_bank), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    $display("[TB] clean frame, re=bin");
    applyStimulus(0, 256, -1, 255, 0);
    drain_and_read();

    $display("[TB] clean frame, re=0x4000");
    applyStimulus(1, 256, -1, 255, 0);
    drain_and_read();

    $display("[TB] random frame with idle gaps");
    applyStimulus(2, 256, -1, 255, 30);
    drain_and_read();

    $display("[TB] short frame, eop at sample 200");
    applyStimulus(2, 200, -1, 199, 0);
    drain_and_read();

    $display("[TB] sop re-injected at sample 100");
    applyStimulus(2, 356, 100, 355, 0);
    drain_and_read();

    $display("[TB] back-to-back frames with concurrent readout");
    fork
      begin
        applyStimulus(2, 256, -1, 255, 0);
        applyStimulus(3, 256, -1, 255, 0);
      end
      read_bins(600);
    join
    drain_and_read();

    applyStimulus(1, 256, -1, 255, 0);
    drain_and_read();

    $display("[TB] reset asserted mid-frame");
    applyStimulus(2, 50, -1, -1, 0);
    @(negedge clk_50m);
    fft_o_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rd_bank", 32'(rd_bank), 32'd0);
    checkOutput("midrst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("midrst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("midrst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("midrst_no_events", 32'(ev_q.size()), 32'd0);
    ev_q.delete();
    m_capt   = 1'b0;
    m_cnt    = 0;
    exp_bank = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(2);
    applyStimulus(2, 256, -1, 255, 10);
    drain_and_read();

    idle_cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
